// File: rtl/boot_loader.sv
// Byte-serial framed image loader: writes .text/.data words into CPU memory
// and holds the CPU in reset until a DONE command arrives.
module boot_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int TEXT_BASE  = 0,
    parameter int DATA_BASE  = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_CMD,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] CMD_TEXT = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h02;
    localparam logic [7:0] CMD_DONE = 8'hFF;

    // Wide enough to hold base + a full 16-bit length without wrapping.
    localparam int                SUM_W     = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;
    localparam logic [SUM_W-1:0]  MEM_WORDS = SUM_W'(1) << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_remaining;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_shift;

    logic                  w_accept;
    logic [15:0]           w_len;
    logic [SUM_W-1:0]      w_end;
    logic                  w_range_err;
    logic                  w_last_word;

    // in_ready is forced low while reset is held, even though the state is CMD.
    assign in_ready    = reset && (r_state != S_DONE) && (r_state != S_ERROR);
    assign cpu_reset   = (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign error       = (r_state == S_ERROR);

    assign w_accept    = in_valid && in_ready;
    assign w_len       = {r_len_hi, in_data};
    assign w_end       = SUM_W'(r_base) + SUM_W'(w_len);
    assign w_range_err = (w_end > MEM_WORDS);
    assign w_last_word = (r_remaining == 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                S_CMD: begin
                    if (in_data == CMD_TEXT || in_data == CMD_DATA) begin
                        w_next_state = S_LEN_HI;
                    end else if (in_data == CMD_DONE) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_ERROR;
                    end
                end
                S_LEN_HI: w_next_state = S_LEN_LO;
                S_LEN_LO: begin
                    if (w_len == 16'd0) begin
                        w_next_state = S_CMD;
                    end else if (w_range_err) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_byte_idx == 2'd3 && w_last_word) begin
                        w_next_state = S_CMD;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base      <= '0;
            r_ptr       <= '0;
            r_len_hi    <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            word_count  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_CMD: begin
                        r_base <= (in_data == CMD_DATA) ? ADDR_WIDTH'(DATA_BASE)
                                                        : ADDR_WIDTH'(TEXT_BASE);
                    end
                    S_LEN_HI: r_len_hi <= in_data;
                    S_LEN_LO: begin
                        r_remaining <= w_len;
                        r_ptr       <= r_base;
                        r_byte_idx  <= 2'd0;
                    end
                    S_DATA: begin
                        r_shift    <= {r_shift[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            mem_we      <= 1'b1;
                            mem_addr    <= r_ptr;
                            mem_wdata   <= {r_shift, in_data};
                            r_ptr       <= r_ptr + ADDR_WIDTH'(1);
                            word_count  <= word_count + (ADDR_WIDTH + 1)'(1);
                            r_remaining <= r_remaining - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader: frames are streamed byte by byte and the
// memory write strobes are collected and compared against hand-computed values.
module tb_boot_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    boot_loader #(
        .ADDR_WIDTH(AW),
        .TEXT_BASE (0),
        .DATA_BASE (2048)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Write monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        wa_q.delete();
        wd_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input string tag);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            checks++;
            if (mem_we !== (i == 3)) begin
                errors++;
                $display("FAIL %s mem_we after byte %0d: got %b expected %b", tag, i, mem_we, (i == 3));
            end
            if (gap) begin
                in_data = 8'h5A;
                @(posedge clk);
                #1;
                checks++;
                if (mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s mem_we in idle after byte %0d: got %b expected 0", tag, i, mem_we);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        checks++;
        if ({in_ready, mem_we, cpu_reset, done, error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset flags {rdy,we,cpu_rst,done,err}: got %b expected 00100",
                     {in_ready, mem_we, cpu_reset, done, error});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0 || word_count !== '0) begin
            errors++;
            $display("FAIL reset datapath: addr=%h wdata=%h count=%0d expected all zero",
                     mem_addr, mem_wdata, word_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_text();
        apply_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20080005, 1'b0, "text w0");
        send_word(32'h0000000C, 1'b0, "text w1");
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL text pre-done cpu_reset/done: got %b/%b expected 1/0", cpu_reset, done);
        end
        send_byte(8'hFF);
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL text done cpu_reset/done/in_ready: got %b/%b/%b expected 0/1/0",
                     cpu_reset, done, in_ready);
        end
        checks++;
        if (wa_q.size() != 2 || wa_q[0] !== 12'd0 || wd_q[0] !== 32'h20080005 ||
            wa_q[1] !== 12'd1 || wd_q[1] !== 32'h0000000C) begin
            errors++;
            $display("FAIL text writes: got %0d writes, first %h:%h expected 2 writes 000:20080005 001:0000000C",
                     wa_q.size(), mem_addr, mem_wdata);
        end
        checks++;
        if (word_count !== 13'd2) begin
            errors++;
            $display("FAIL text word_count: got %0d expected 2", word_count);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 12'd1 || mem_wdata !== 32'h0000000C) begin
            errors++;
            $display("FAIL text hold: we=%b addr=%h wdata=%h expected 0/001/0000000C",
                     mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_data();
        apply_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDEADBEEF, 1'b0, "data w0");
        send_byte(8'hFF);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 12'd2048 || wd_q[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL data write: got %0d writes last %h:%h expected 1 write 800:DEADBEEF",
                     wa_q.size(), mem_addr, mem_wdata);
        end
        checks++;
        if (done !== 1'b1 || word_count !== 13'd1) begin
            errors++;
            $display("FAIL data done/word_count: got %b/%0d expected 1/1", done, word_count);
        end
    endtask

    task automatic test_throttled();
        apply_reset();
        send_byte(8'h01);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20080005, 1'b1, "gap w0");
        send_word(32'h0000000C, 1'b1, "gap w1");
        send_byte(8'hFF);
        checks++;
        if (wa_q.size() != 2 || wa_q[0] !== 12'd0 || wd_q[0] !== 32'h20080005 ||
            wa_q[1] !== 12'd1 || wd_q[1] !== 32'h0000000C) begin
            errors++;
            $display("FAIL gap writes: got %0d writes expected 2 writes 000:20080005 001:0000000C",
                     wa_q.size());
        end
        checks++;
        if (done !== 1'b1 || word_count !== 13'd2) begin
            errors++;
            $display("FAIL gap done/word_count: got %b/%0d expected 1/2", done, word_count);
        end
    endtask

    task automatic test_bad_cmd();
        apply_reset();
        send_byte(8'h07);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL badcmd error/in_ready/cpu_reset: got %b/%b/%b expected 1/0/1",
                     error, in_ready, cpu_reset);
        end
        send_byte(8'hFF);
        send_byte(8'h01);
        checks++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL badcmd after FF done/error/cpu_reset: got %b/%b/%b expected 0/1/1",
                     done, error, cpu_reset);
        end
        checks++;
        if (wa_q.size() != 0 || word_count !== '0) begin
            errors++;
            $display("FAIL badcmd writes: got %0d writes count %0d expected 0/0", wa_q.size(), word_count);
        end
    endtask

    task automatic test_range();
        int bad;
        apply_reset();
        send_byte(8'h02);
        send_byte(8'h08);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL range early error after LEN_HI: got %b expected 0", error);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (error !== 1'b1 || wa_q.size() != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL range N=2049 error/writes/in_ready: got %b/%0d/%b expected 1/0/0",
                     error, wa_q.size(), in_ready);
        end

        apply_reset();
        send_byte(8'h02);
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            send_word(32'hA5000000 + i, 1'b0, "range fill");
        end
        send_byte(8'hFF);
        checks++;
        if (error !== 1'b0 || done !== 1'b1 || word_count !== 13'd2048) begin
            errors++;
            $display("FAIL range N=2048 error/done/count: got %b/%b/%0d expected 0/1/2048",
                     error, done, word_count);
        end
        bad = 0;
        if (wa_q.size() != 2048) begin
            bad = 1;
        end else begin
            for (int i = 0; i < 2048; i++) begin
                if (wa_q[i] !== 12'(2048 + i) || wd_q[i] !== 32'hA5000000 + i) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL range fill sequence: %0d bad entries of %0d writes expected 0 bad of 2048",
                     bad, wa_q.size());
        end
        checks++;
        if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 12'd4095) begin
            errors++;
            $display("FAIL range last addr: got %h expected FFF", mem_addr);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || mem_we !== 1'b0 || word_count !== '0) begin
            errors++;
            $display("FAIL midreset rdy/cpu_rst/we/count: got %b/%b/%b/%0d expected 0/1/0/0",
                     in_ready, cpu_reset, mem_we, word_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h11223344, 1'b0, "midreset w0");
        send_byte(8'hFF);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 12'd0 || wd_q[0] !== 32'h11223344) begin
            errors++;
            $display("FAIL midreset write: got %0d writes last %h:%h expected 1 write 000:11223344",
                     wa_q.size(), mem_addr, mem_wdata);
        end
        checks++;
        if (word_count !== 13'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset count/done: got %0d/%b expected 1/1", word_count, done);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304, 1'b0, "b2b w0");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h12345678, 1'b0, "b2b w1");
        send_word(32'h9ABCDEF0, 1'b0, "b2b w2");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D, 1'b0, "b2b w3");
        send_byte(8'hFF);
        checks++;
        if (wa_q.size() != 4 ||
            wa_q[0] !== 12'd2048 || wd_q[0] !== 32'h01020304 ||
            wa_q[1] !== 12'd0    || wd_q[1] !== 32'h12345678 ||
            wa_q[2] !== 12'd1    || wd_q[2] !== 32'h9ABCDEF0 ||
            wa_q[3] !== 12'd0    || wd_q[3] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b write sequence: got %0d writes last %h:%h expected 4 writes ending 000:CAFEF00D",
                     wa_q.size(), mem_addr, mem_wdata);
        end
        checks++;
        if (word_count !== 13'd4 || done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b count/done/error: got %0d/%b/%b expected 4/1/0", word_count, done, error);
        end
    endtask

    initial begin
        test_reset();
        test_text();
        test_data();
        test_throttled();
        test_bad_cmd();
        test_range();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
